// File: rtl/shift_pkg.sv
// Shared types and helpers for the shift/rotate execution unit.
package shift_pkg;

    localparam int SHIFT_OP_WIDTH = 3;

    typedef enum logic [SHIFT_OP_WIDTH-1:0] {
        SLL = 3'd0,
        SRL = 3'd1,
        SRA = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4
    } shift_op_e;

    // Shifter levels handled by each pipeline stage (ceiling division).
    function automatic int levelsPerStage(input int bit_width, input int num_stages);
        int levels;
        levels = $clog2(bit_width);
        return (levels + num_stages - 1) / num_stages;
    endfunction

endpackage

// File: rtl/shift_exec_unit_if.sv
// Issue and writeback bus of the shift execution unit; master = issue/writeback side.
interface shift_exec_unit_if #(
    parameter int BIT_WIDTH = 32,
    parameter int TAG_WIDTH = 6
);
    import shift_pkg::*;

    logic                         flush;
    logic                         inValid;
    logic                         inReady;
    logic [SHIFT_OP_WIDTH-1:0]    inOp;
    logic [BIT_WIDTH-1:0]         inData;
    logic [$clog2(BIT_WIDTH)-1:0] shiftAmt;
    logic [TAG_WIDTH-1:0]         inTag;
    logic                         outValid;
    logic                         outReady;
    logic [BIT_WIDTH-1:0]         outData;
    logic [TAG_WIDTH-1:0]         outTag;

    modport master (
        output flush, inValid, inOp, inData, shiftAmt, inTag, outReady,
        input  inReady, outValid, outData, outTag
    );

    modport slave (
        input  flush, inValid, inOp, inData, shiftAmt, inTag, outReady,
        output inReady, outValid, outData, outTag
    );

endinterface

// File: rtl/shift_stage.sv
// One pipeline stage: applies shifter levels [LO_LEVEL, HI_LEVEL] and registers the result.
// Rotate wrap paths exist only when SHIFT_ROTATE_EN is defined.
module shift_stage
    import shift_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int TAG_WIDTH = 6,
    parameter int LO_LEVEL  = 0,
    parameter int HI_LEVEL  = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         load_i,
    input  logic                         in_valid_i,
    input  logic [SHIFT_OP_WIDTH-1:0]    in_op_i,
    input  logic [BIT_WIDTH-1:0]         in_data_i,
    input  logic [$clog2(BIT_WIDTH)-1:0] in_amt_i,
    input  logic                         in_fill_i,
    input  logic [TAG_WIDTH-1:0]         in_tag_i,
    output logic                         valid_o,
    output logic [SHIFT_OP_WIDTH-1:0]    op_o,
    output logic [BIT_WIDTH-1:0]         data_o,
    output logic [$clog2(BIT_WIDTH)-1:0] amt_o,
    output logic                         fill_o,
    output logic [TAG_WIDTH-1:0]         tag_o
);

    logic                         valid_q, valid_d;
    logic [SHIFT_OP_WIDTH-1:0]    op_q, op_d;
    logic [BIT_WIDTH-1:0]         data_q, data_d;
    logic [$clog2(BIT_WIDTH)-1:0] amt_q, amt_d;
    logic                         fill_q, fill_d;
    logic [TAG_WIDTH-1:0]         tag_q, tag_d;
    logic [BIT_WIDTH-1:0]         shifted_s;
    logic [$clog2(BIT_WIDTH)-1:0] amt_shr_s;

    // Single shifter level by sh bits; unknown ops (and rotates when not built) pass through.
    function automatic logic [BIT_WIDTH-1:0] shift_level(
        input logic [SHIFT_OP_WIDTH-1:0] op,
        input logic [BIT_WIDTH-1:0]      d,
        input logic                      fill,
        input int unsigned               sh
    );
        logic [BIT_WIDTH-1:0] ones;
        ones = {BIT_WIDTH{1'b1}};
        case (op)
            SLL:     return d << sh;
            SRL:     return d >> sh;
            SRA:     return (d >> sh) | (fill ? ~(ones >> sh) : {BIT_WIDTH{1'b0}});
`ifdef SHIFT_ROTATE_EN
            ROL:     return (d << sh) | (d >> (BIT_WIDTH - sh));
            ROR:     return (d >> sh) | (d << (BIT_WIDTH - sh));
`endif
            default: return d;
        endcase
    endfunction

    // Level chain for this stage's slice of the shift amount.
    always_comb begin
        shifted_s = in_data_i;
        amt_shr_s = {$clog2(BIT_WIDTH){1'b0}};
        for (int lvl = LO_LEVEL; lvl <= HI_LEVEL; lvl++) begin
            amt_shr_s = in_amt_i >> lvl;
            if (amt_shr_s[0]) begin
                shifted_s = shift_level(in_op_i, shifted_s, in_fill_i, 32'd1 << lvl);
            end else begin
                shifted_s = shifted_s;
            end
        end
    end

    // Next-state: flush only kills the valid bit, payload is left as is.
    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        data_d  = data_q;
        amt_d   = amt_q;
        fill_d  = fill_q;
        tag_d   = tag_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = in_valid_i;
        end else begin
            valid_d = valid_q;
        end
        if (load_i && in_valid_i) begin
            op_d   = in_op_i;
            data_d = shifted_s;
            amt_d  = in_amt_i;
            fill_d = in_fill_i;
            tag_d  = in_tag_i;
        end else begin
            op_d   = op_q;
            data_d = data_q;
        end
    end

    // Stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            op_q    <= {SHIFT_OP_WIDTH{1'b0}};
            data_q  <= {BIT_WIDTH{1'b0}};
            amt_q   <= {$clog2(BIT_WIDTH){1'b0}};
            fill_q  <= 1'b0;
            tag_q   <= {TAG_WIDTH{1'b0}};
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            fill_q  <= fill_d;
            tag_q   <= tag_d;
        end
    end

    assign valid_o = valid_q;
    assign op_o    = op_q;
    assign data_o  = data_q;
    assign amt_o   = amt_q;
    assign fill_o  = fill_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/shift_exec_unit.sv
// Pipelined shift/rotate unit: NUM_STAGES shift_stage copies with elastic valid/ready flow.
// Define SHIFT_ROTATE_EN to build ROL/ROR; otherwise they pass the operand through.
module shift_exec_unit
    import shift_pkg::*;
#(
    parameter int BIT_WIDTH  = 32,
    parameter int NUM_STAGES = 2,
    parameter int TAG_WIDTH  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_exec_unit_if.slave  io
);

    localparam int LEVELS = $clog2(BIT_WIDTH);
    localparam int LPS    = levelsPerStage(BIT_WIDTH, NUM_STAGES);

    logic [NUM_STAGES-1:0]     valid_s;
    logic [NUM_STAGES-1:0]     load_s;
    logic [SHIFT_OP_WIDTH-1:0] op_s      [NUM_STAGES];
    logic [BIT_WIDTH-1:0]      data_s    [NUM_STAGES];
    logic [LEVELS-1:0]         amt_s     [NUM_STAGES];
    logic                      fill_s    [NUM_STAGES];
    logic [TAG_WIDTH-1:0]      tag_s     [NUM_STAGES];
    logic                      in_valid_s[NUM_STAGES];
    logic [SHIFT_OP_WIDTH-1:0] in_op_s   [NUM_STAGES];
    logic [BIT_WIDTH-1:0]      in_data_s [NUM_STAGES];
    logic [LEVELS-1:0]         in_amt_s  [NUM_STAGES];
    logic                      in_fill_s [NUM_STAGES];
    logic [TAG_WIDTH-1:0]      in_tag_s  [NUM_STAGES];
    logic                      unused_s;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam int LO      = k * LPS;
        localparam int END_RAW = ((k + 1) * LPS < LEVELS) ? (k + 1) * LPS : LEVELS;
        localparam int HI      = ((END_RAW > LO) ? END_RAW : LO) - 1;

        // Stage k moves when a bubble exists at or downstream of it, or the output drains.
        assign load_s[k] = io.outReady || !(&valid_s[NUM_STAGES-1:k]);

        if (k == 0) begin : g_head
            // SRA fill bit is captured from the operand at acceptance.
            assign in_valid_s[k] = io.inValid;
            assign in_op_s[k]    = io.inOp;
            assign in_data_s[k]  = io.inData;
            assign in_amt_s[k]   = io.shiftAmt;
            assign in_fill_s[k]  = io.inData[BIT_WIDTH-1];
            assign in_tag_s[k]   = io.inTag;
        end else begin : g_body
            assign in_valid_s[k] = valid_s[k-1];
            assign in_op_s[k]    = op_s[k-1];
            assign in_data_s[k]  = data_s[k-1];
            assign in_amt_s[k]   = amt_s[k-1];
            assign in_fill_s[k]  = fill_s[k-1];
            assign in_tag_s[k]   = tag_s[k-1];
        end

        shift_stage #(
            .BIT_WIDTH (BIT_WIDTH),
            .TAG_WIDTH (TAG_WIDTH),
            .LO_LEVEL  (LO),
            .HI_LEVEL  (HI)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush_i    (io.flush),
            .load_i     (load_s[k]),
            .in_valid_i (in_valid_s[k]),
            .in_op_i    (in_op_s[k]),
            .in_data_i  (in_data_s[k]),
            .in_amt_i   (in_amt_s[k]),
            .in_fill_i  (in_fill_s[k]),
            .in_tag_i   (in_tag_s[k]),
            .valid_o    (valid_s[k]),
            .op_o       (op_s[k]),
            .data_o     (data_s[k]),
            .amt_o      (amt_s[k]),
            .fill_o     (fill_s[k]),
            .tag_o      (tag_s[k])
        );
    end

    assign io.inReady  = load_s[0] && !io.flush;
    assign io.outValid = valid_s[NUM_STAGES-1];
    assign io.outData  = data_s[NUM_STAGES-1];
    assign io.outTag   = tag_s[NUM_STAGES-1];

    // Control fields of the last stage have no further consumer.
    assign unused_s = ^{op_s[NUM_STAGES-1], amt_s[NUM_STAGES-1], fill_s[NUM_STAGES-1]};

endmodule

// File: tb/tb_shift_exec_unit.sv
// Self-checking bench for shift_exec_unit: directed cases plus randomized traffic vs a scoreboard model.
module tb_shift_exec_unit;

    localparam int W  = 32;
    localparam int NS = 2;
    localparam int TW = 6;
    localparam int AW = $clog2(W);

    typedef struct {
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
    } item_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    item_t         model_q[$];
    logic [TW-1:0] delivered_tags[$];

    shift_exec_unit_if #(.BIT_WIDTH(W), .TAG_WIDTH(TW)) bus ();

    shift_exec_unit #(.BIT_WIDTH(W), .NUM_STAGES(NS), .TAG_WIDTH(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference result from the operation definitions.
    function automatic logic [W-1:0] ref_shift(input logic [2:0] op, input logic [W-1:0] d,
                                               input logic [AW-1:0] amt);
        logic [2*W-1:0] dbl;
        logic [W-1:0]   r;
        dbl = {d, d};
        case (op)
            3'd0: r = d << amt;
            3'd1: r = d >> amt;
            3'd2: r = $signed(d) >>> amt;
`ifdef SHIFT_ROTATE_EN
            3'd3: begin dbl = dbl << amt; r = dbl[2*W-1:W]; end
            3'd4: begin dbl = dbl >> amt; r = dbl[W-1:0];   end
`endif
            default: r = d;
        endcase
        return r;
    endfunction

    // Compare process: checks outputs and applies the transfers of the coming edge to the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_q.delete();
            check("rst_out_valid", {63'd0, bus.outValid}, 64'd0);
            check("rst_out_data", {32'd0, bus.outData}, 64'd0);
            check("rst_out_tag", {58'd0, bus.outTag}, 64'd0);
        end else begin
            check("in_ready", {63'd0, bus.inReady},
                  {63'd0, !bus.flush && ((model_q.size() < NS) || bus.outReady)});
            if (model_q.size() == 0) begin
                check("out_idle", {63'd0, bus.outValid}, 64'd0);
            end else if (bus.outValid) begin
                check("out_data", {32'd0, bus.outData}, {32'd0, model_q[0].data});
                check("out_tag", {58'd0, bus.outTag}, {58'd0, model_q[0].tag});
            end
            if (bus.outValid && bus.outReady && model_q.size() > 0) begin
                delivered_tags.push_back(bus.outTag);
                void'(model_q.pop_front());
            end
            if (bus.flush) begin
                model_q.delete();
            end else if (bus.inValid && bus.inReady) begin
                model_q.push_back('{ref_shift(bus.inOp, bus.inData, bus.shiftAmt), bus.inTag});
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [W-1:0] d, input logic [AW-1:0] amt,
                         input logic [TW-1:0] tag);
        bus.inValid  = 1'b1;
        bus.inOp     = op;
        bus.inData   = d;
        bus.shiftAmt = amt;
        bus.inTag    = tag;
    endtask

    // Single op on an empty pipe with outReady high; pins model, data, tag and latency.
    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] d,
                          input logic [AW-1:0] amt, input logic [TW-1:0] tag, input logic [W-1:0] exp);
        int cyc;
        bit seen;
        check({name, "_model"}, {32'd0, ref_shift(op, d, amt)}, {32'd0, exp});
        drive(op, d, amt, tag);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 10) begin
            @(posedge clk); #1;
            bus.inValid = 1'b0;
            cyc++;
            if (bus.outValid) seen = 1'b1;
        end
        check({name, "_latency"}, 64'(cyc), 64'(NS));
        check({name, "_data"}, {32'd0, bus.outData}, {32'd0, exp});
        check({name, "_tag"}, {58'd0, bus.outTag}, {58'd0, tag});
    endtask

    task automatic wait_delivered(input int n);
        int cyc;
        cyc = 0;
        while (delivered_tags.size() < n && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        logic [W-1:0] rot_r_exp;
        logic [W-1:0] rot_l_exp;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.flush    = 1'b0;
        bus.inValid  = 1'b0;
        bus.inOp     = 3'd0;
        bus.inData   = 32'd0;
        bus.shiftAmt = 5'd0;
        bus.inTag    = 6'd0;
        bus.outReady = 1'b0;

        #12;
        check("reset_valid", {63'd0, bus.outValid}, 64'd0);
        check("reset_data", {32'd0, bus.outData}, 64'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", {63'd0, bus.inReady}, 64'd1);
        bus.outReady = 1'b1;

`ifdef SHIFT_ROTATE_EN
        rot_r_exp = 32'h8000_0000;
        rot_l_exp = 32'h0000_0018;
`else
        rot_r_exp = 32'h0000_0001;
        rot_l_exp = 32'h8000_0001;
`endif
        run_op("sra", 3'd2, 32'h8000_0000, 5'd4, 6'd5, 32'hF800_0000);
        run_op("srl", 3'd1, 32'h8000_0000, 5'd4, 6'd5, 32'h0800_0000);
        run_op("sll31", 3'd0, 32'hFFFF_FFFF, 5'd31, 6'd6, 32'h8000_0000);
        run_op("srl0", 3'd1, 32'h1234_5678, 5'd0, 6'd7, 32'h1234_5678);
        run_op("illegal", 3'd6, 32'hA5A5_A5A5, 5'd9, 6'd8, 32'hA5A5_A5A5);
        run_op("ror", 3'd4, 32'h0000_0001, 5'd1, 6'd9, rot_r_exp);
        run_op("rol", 3'd3, 32'h8000_0001, 5'd4, 6'd10, rot_l_exp);
        run_op("sra_pos", 3'd2, 32'h7000_0000, 5'd31, 6'd11, 32'h0000_0000);

        // Backpressure: two fit, the third waits until the output drains.
        @(posedge clk); #1;
        delivered_tags.delete();
        bus.outReady = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            drive(3'd0, 32'(t), 5'd0, 6'(t));
            if (t == 3) begin
                @(negedge clk);
                check("bp_stall_ready", {63'd0, bus.inReady}, 64'd0);
                @(posedge clk); #1;
                @(negedge clk);
                check("bp_stall_ready2", {63'd0, bus.inReady}, 64'd0);
                @(posedge clk); #1;
                bus.outReady = 1'b1;
            end
            @(negedge clk);
            check("bp_ready", {63'd0, bus.inReady}, 64'd1);
            @(posedge clk); #1;
        end
        bus.inValid = 1'b0;
        wait_delivered(4);
        check("bp_count", 64'(delivered_tags.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < delivered_tags.size()) check("bp_order", {58'd0, delivered_tags[i]}, 64'(i + 1));
        end

        // Flush kills everything in flight and the op offered alongside it.
        @(posedge clk); #1;
        delivered_tags.delete();
        bus.outReady = 1'b0;
        drive(3'd1, 32'hFFFF_0000, 5'd4, 6'd7);
        @(posedge clk); #1;
        drive(3'd1, 32'hFFFF_0000, 5'd8, 6'd8);
        @(posedge clk); #1;
        drive(3'd1, 32'hFFFF_0000, 5'd2, 6'd9);
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_ready", {63'd0, bus.inReady}, 64'd0);
        @(posedge clk); #1;
        bus.flush    = 1'b0;
        bus.inValid  = 1'b0;
        bus.outReady = 1'b1;
        check("flush_out_valid", {63'd0, bus.outValid}, 64'd0);
        repeat (4) @(posedge clk);
        #1;
        check("flush_none_out", 64'(delivered_tags.size()), 64'd0);
        run_op("after_flush", 3'd0, 32'h0000_00FF, 5'd8, 6'd10, 32'h0000_FF00);

        // Asynchronous reset mid-flight.
        @(posedge clk); #1;
        delivered_tags.delete();
        bus.outReady = 1'b0;
        drive(3'd0, 32'hDEAD_BEEF, 5'd0, 6'd11);
        @(posedge clk); #1;
        drive(3'd0, 32'hCAFE_F00D, 5'd0, 6'd12);
        @(posedge clk); #1;
        bus.inValid = 1'b0;
        check("pre_rst_valid", {63'd0, bus.outValid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {63'd0, bus.outValid}, 64'd0);
        check("async_rst_data", {32'd0, bus.outData}, 64'd0);
        check("async_rst_tag", {58'd0, bus.outTag}, 64'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.outReady = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_no_stale", 64'(delivered_tags.size()), 64'd0);
        check("rst_ready", {63'd0, bus.inReady}, 64'd1);

        // Randomized traffic with backpressure and occasional flushes.
        for (int i = 0; i < 600; i++) begin
            bus.inValid  = ($urandom_range(0, 9) < 7);
            bus.inOp     = 3'($urandom_range(0, 7));
            bus.inData   = $urandom();
            bus.shiftAmt = 5'($urandom_range(0, 31));
            bus.inTag    = 6'($urandom_range(0, 63));
            bus.outReady = ($urandom_range(0, 9) < 6);
            bus.flush    = ($urandom_range(0, 39) == 0);
            @(posedge clk); #1;
        end
        bus.inValid  = 1'b0;
        bus.flush    = 1'b0;
        bus.outReady = 1'b1;
        for (int c = 0; c < 20 && (model_q.size() != 0 || bus.outValid); c++) begin
            @(posedge clk); #1;
        end
        check("drain_model_empty", 64'(model_q.size()), 64'd0);
        check("drain_out_valid", {63'd0, bus.outValid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
